// File: rtl/sfifo_reg_flag_if.sv
// Stream/status bundle of the register FIFO: producer/consumer side is master, FIFO is slave.
interface sfifo_reg_flag_if #(
  parameter int DW      = 32,
  parameter int LEN_LOG = 2
);
  logic               FLUSH;
  logic               enq;
  logic               deq;
  logic [DW-1:0]      din;
  logic [DW-1:0]      dot;
  logic               dvld;
  logic               full;
  logic               empty;
  logic               afull;
  logic               aempty;
  logic [LEN_LOG:0]   cnt;
  logic               ovf;
  logic               udf;

  modport master (
    output FLUSH, enq, deq, din,
    input  dot, dvld, full, empty, afull, aempty, cnt, ovf, udf
  );
  modport slave (
    input  FLUSH, enq, deq, din,
    output dot, dvld, full, empty, afull, aempty, cnt, ovf, udf
  );
endinterface

// File: rtl/sfifo_reg_flag.sv
// Single-clock register-array FIFO with occupancy, threshold flags, sticky errors,
// synchronous flush and selectable FWFT / registered read.
module sfifo_reg_flag #(
   parameter  int DW      = 32,
   parameter  int LEN_LOG = 2,
   localparam int LEN     = 1 << LEN_LOG,
   parameter  int FWFT    = 1,
   parameter  int AF_TH   = LEN - 1,
   parameter  int AE_TH   = 1
) (
   input  logic            CLK,
   input  logic            RST,
   sfifo_reg_flag_if.slave f
);
   localparam int PW = LEN_LOG + 1;

   logic [DW-1:0]      mem [LEN];
   logic [PW-1:0]      wptr, rptr, cnt_w;
   logic [LEN_LOG-1:0] widx, ridx;
   logic               full_w, empty_w, we, re;
   logic               ovf_q, udf_q;

   assign widx    = wptr[LEN_LOG-1:0];
   assign ridx    = rptr[LEN_LOG-1:0];
   assign cnt_w   = wptr - rptr;
   assign full_w  = (wptr[PW-1] != rptr[PW-1]) && (widx == ridx);
   assign empty_w = (wptr == rptr);
   // flush swallows both requests of its cycle
   assign we      = f.enq & ~full_w  & ~f.FLUSH;
   assign re      = f.deq & ~empty_w & ~f.FLUSH;

   assign f.cnt    = cnt_w;
   assign f.full   = full_w;
   assign f.empty  = empty_w;
   assign f.afull  = (cnt_w >= PW'(AF_TH));
   assign f.aempty = (cnt_w <= PW'(AE_TH));
   assign f.ovf    = ovf_q;
   assign f.udf    = udf_q;

   always_ff @(posedge CLK) begin
      if (we) mem[widx] <= f.din;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr  <= '0;
         rptr  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else if (f.FLUSH) begin
         wptr  <= '0;
         rptr  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (we) wptr <= wptr + PW'(1);
         if (re) rptr <= rptr + PW'(1);
         if (f.enq & full_w)  ovf_q <= 1'b1;
         if (f.deq & empty_w) udf_q <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign f.dot  = mem[ridx];
         assign f.dvld = ~empty_w;
      end else begin : g_reg
         logic [DW-1:0] dot_q;
         logic          dvld_q;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               dot_q  <= '0;
               dvld_q <= 1'b0;
            end else if (f.FLUSH) begin
               dot_q  <= '0;
               dvld_q <= 1'b0;
            end else begin
               dvld_q <= re;
               if (re) dot_q <= mem[ridx];
            end
         end
         assign f.dot  = dot_q;
         assign f.dvld = dvld_q;
      end
   endgenerate
endmodule

// File: tb/tb_sfifo_reg_flag.sv
// Directed bench for sfifo_reg_flag: FWFT and registered-read instances against a queue model.
module tb_sfifo_reg_flag;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   sfifo_reg_flag_if #(.DW(8), .LEN_LOG(2)) f1 ();
   sfifo_reg_flag_if #(.DW(8), .LEN_LOG(2)) f0 ();

   sfifo_reg_flag #(.DW(8), .LEN_LOG(2), .FWFT(1)) u1 (.CLK(CLK), .RST(RST), .f(f1));
   sfifo_reg_flag #(.DW(8), .LEN_LOG(2), .FWFT(0)) u0 (.CLK(CLK), .RST(RST), .f(f0));

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // queue model: 4-deep, afull at >=3, aempty at <=1
   logic [7:0] q1[$];
   logic [7:0] q0[$];
   bit   m1_ovf, m1_udf, m0_ovf, m0_udf, m0_dvld;
   logic [7:0] m0_dot;
   bit   fl1, em1, fl0, em0;

   always @(posedge CLK or posedge RST) begin
      if (RST || f1.FLUSH) begin
         q1.delete(); m1_ovf = 0; m1_udf = 0;
      end else begin
         fl1 = (q1.size() == 4); em1 = (q1.size() == 0);
         if (f1.enq && fl1) m1_ovf = 1;
         if (f1.deq && em1) m1_udf = 1;
         if (f1.deq && !em1) void'(q1.pop_front());
         if (f1.enq && !fl1) q1.push_back(f1.din);
      end
      if (RST || f0.FLUSH) begin
         q0.delete(); m0_ovf = 0; m0_udf = 0; m0_dvld = 0; m0_dot = 8'h00;
      end else begin
         fl0 = (q0.size() == 4); em0 = (q0.size() == 0);
         if (f0.enq && fl0) m0_ovf = 1;
         if (f0.deq && em0) m0_udf = 1;
         m0_dvld = f0.deq && !em0;
         if (m0_dvld) m0_dot = q0.pop_front();
         if (f0.enq && !fl0) q0.push_back(f0.din);
      end
   end

   always @(negedge CLK) begin
      chk("u1_cnt",    f1.cnt,    q1.size());
      chk("u1_full",   f1.full,   q1.size() == 4);
      chk("u1_empty",  f1.empty,  q1.size() == 0);
      chk("u1_afull",  f1.afull,  q1.size() >= 3);
      chk("u1_aempty", f1.aempty, q1.size() <= 1);
      chk("u1_ovf",    f1.ovf,    m1_ovf);
      chk("u1_udf",    f1.udf,    m1_udf);
      chk("u1_dvld",   f1.dvld,   q1.size() != 0);
      if (q1.size() != 0) chk("u1_dot", f1.dot, q1[0]);
      chk("u0_cnt",    f0.cnt,    q0.size());
      chk("u0_full",   f0.full,   q0.size() == 4);
      chk("u0_empty",  f0.empty,  q0.size() == 0);
      chk("u0_ovf",    f0.ovf,    m0_ovf);
      chk("u0_udf",    f0.udf,    m0_udf);
      chk("u0_dvld",   f0.dvld,   m0_dvld);
      chk("u0_dot",    f0.dot,    m0_dot);
   end

   task automatic cy1(input logic e, input logic d, input logic [7:0] v, input logic fl);
      f1.enq = e; f1.deq = d; f1.din = v; f1.FLUSH = fl;
      @(posedge CLK); #1;
      f1.enq = 0; f1.deq = 0; f1.FLUSH = 0;
   endtask

   task automatic cy0(input logic e, input logic d, input logic [7:0] v, input logic fl);
      f0.enq = e; f0.deq = d; f0.din = v; f0.FLUSH = fl;
      @(posedge CLK); #1;
      f0.enq = 0; f0.deq = 0; f0.FLUSH = 0;
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_d [4];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
      f1.enq = 0; f1.deq = 0; f1.din = 0; f1.FLUSH = 0;
      f0.enq = 0; f0.deq = 0; f0.din = 0; f0.FLUSH = 0;
      repeat (2) @(posedge CLK);
      #1 RST = 0;
      chk("rst_cnt", f1.cnt, 0);
      chk("rst_empty", f1.empty, 1);
      chk("rst_aempty", f1.aempty, 1);
      chk("rst_afull", f1.afull, 0);

      // fill
      cy1(1, 0, 8'h11, 0); cy1(1, 0, 8'h22, 0);
      chk("fill2_afull", f1.afull, 0);
      cy1(1, 0, 8'h33, 0);
      chk("fill3_afull", f1.afull, 1);
      chk("fill3_full", f1.full, 0);
      cy1(1, 0, 8'h44, 0);
      chk("fill4_full", f1.full, 1);
      chk("fill4_cnt", f1.cnt, 4);
      chk("fill4_dot", f1.dot, 8'h11);
      chk("fill4_dvld", f1.dvld, 1);
      chk("fill4_ovf", f1.ovf, 0);

      // overflow then drain
      cy1(1, 0, 8'h55, 0);
      chk("ovf_set", f1.ovf, 1);
      chk("ovf_cnt", f1.cnt, 4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_dot", f1.dot, exp_d[i]);
         cy1(0, 1, 8'h00, 0);
         chk("drain_aempty", f1.aempty, (i >= 2));
      end
      chk("drain_empty", f1.empty, 1);
      chk("drain_udf0", f1.udf, 0);
      cy1(0, 1, 8'h00, 0);
      chk("udf_set", f1.udf, 1);

      // simultaneous at cnt=2, crosses the wrap point twice
      cy1(1, 0, 8'h60, 0); cy1(1, 0, 8'h61, 0);
      for (int i = 0; i < 10; i++) begin
         chk("sim_dot", f1.dot, 8'h60 + i);
         cy1(1, 1, 8'h62 + i, 0);
         chk("sim_cnt", f1.cnt, 2);
      end
      chk("sim_dot_end", f1.dot, 8'h6A);

      // full corner: enq+deq while full
      cy1(0, 0, 8'h00, 1);
      chk("flush_ovf", f1.ovf, 0);
      chk("flush_udf", f1.udf, 0);
      for (int i = 0; i < 4; i++) cy1(1, 0, 8'h80 + i, 0);
      cy1(1, 1, 8'h84, 0);
      chk("corner_cnt", f1.cnt, 3);
      chk("corner_ovf", f1.ovf, 1);
      chk("corner_dot", f1.dot, 8'h81);

      // flush with enq at cnt=3, ovf=1
      cy1(1, 0, 8'h99, 1);
      chk("fl_cnt", f1.cnt, 0);
      chk("fl_ovf", f1.ovf, 0);
      chk("fl_empty", f1.empty, 1);
      cy1(1, 0, 8'hB0, 0); cy1(1, 0, 8'hB1, 0);
      chk("pre_rst_cnt", f1.cnt, 2);
      #2 RST = 1;
      #1;
      chk("async_rst_cnt", f1.cnt, 0);
      chk("async_rst_empty", f1.empty, 1);
      RST = 0;
      @(posedge CLK); #1;

      // registered read
      chk("r0_dvld", f0.dvld, 0);
      chk("r0_dot", f0.dot, 0);
      cy0(1, 0, 8'hA5, 0); cy0(1, 0, 8'h5A, 0);
      chk("r0_dvld_nodeq", f0.dvld, 0);
      cy0(0, 1, 8'h00, 0);
      chk("r0_dvld1", f0.dvld, 1);
      chk("r0_dotA5", f0.dot, 8'hA5);
      cy0(0, 0, 8'h00, 0);
      chk("r0_idle_dvld", f0.dvld, 0);
      chk("r0_idle_dot", f0.dot, 8'hA5);
      cy0(0, 1, 8'h00, 0);
      chk("r0_dot5A", f0.dot, 8'h5A);
      cy0(0, 1, 8'h00, 0);
      chk("r0_udf", f0.udf, 1);
      chk("r0_empty_dvld", f0.dvld, 0);
      chk("r0_hold", f0.dot, 8'h5A);
      cy0(1, 0, 8'hC3, 1);
      chk("r0_flush_dot", f0.dot, 0);
      chk("r0_flush_cnt", f0.cnt, 0);
      repeat (2) @(posedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
